pc_sequencer: RTL and testbench

//  Program-counter stage directly upstream of instruction fetch: owns the PC register and drives the fetch

---
 rtl/pc_seq_pkg.sv | 7 +
 rtl/pc_target_calc.sv | 21 ++
 rtl/pc_sequencer.sv | 98 +++++++++
 tb/tb_pc_sequencer.sv | 118 +++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;
   typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} pc_state_t;
   localparam int INSN_BYTES = 4;
   localparam int JUMP_IDX_W = 26;
   localparam int BR_IMM_W   = 16;
endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-address arithmetic: sequential, branch and jump targets from the current pc.
module pc_target_calc
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0]     pc,
   input  logic [BR_IMM_W-1:0]   br_imm,
   input  logic [JUMP_IDX_W-1:0] jump_idx,
   output logic [ADDR_W-1:0]     pc_plus4,
   output logic [ADDR_W-1:0]     br_tgt,
   output logic [ADDR_W-1:0]     jmp_tgt
);
   logic [ADDR_W-1:0] br_off;

   assign pc_plus4 = pc + ADDR_W'(INSN_BYTES);
   // word offset sign-extended and scaled to bytes
   assign br_off   = {{(ADDR_W-BR_IMM_W-2){br_imm[BR_IMM_W-1]}}, br_imm, 2'b00};
   assign br_tgt   = pc_plus4 + br_off;
   assign jmp_tgt  = {pc_plus4[ADDR_W-1:JUMP_IDX_W+2], jump_idx, 2'b00};
endmodule

// File: rtl/pc_sequencer.sv
// PC register and fetch-address FSM. Optional redirect alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int ENTRY_PC = 128,
   parameter int ADDR_W   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  halt,
   input  logic                  br_taken,
   input  logic [BR_IMM_W-1:0]   br_imm,
   input  logic                  jump,
   input  logic [JUMP_IDX_W-1:0] jump_idx,
   output logic [ADDR_W-1:0]     pc,
   output logic [ADDR_W-1:0]     pc_plus4,
   output logic                  valid,
   output logic                  fault
);
   pc_state_t         state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic              pend_vld_reg, pend_vld_next;
   logic [ADDR_W-1:0] pend_tgt_reg, pend_tgt_next;
   logic [ADDR_W-1:0] br_tgt, jmp_tgt, redir_tgt, apply_tgt;
   logic              redir_req, apply, misalign;

   pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
      .pc       (pc_reg),
      .br_imm   (br_imm),
      .jump_idx (jump_idx),
      .pc_plus4 (pc_plus4),
      .br_tgt   (br_tgt),
      .jmp_tgt  (jmp_tgt)
   );

   assign redir_req = jump | br_taken;
   assign redir_tgt = jump ? jmp_tgt : br_tgt;
   // a held redirect takes precedence over anything presented in the same cycle
   assign apply     = (state_reg == RUN) && !halt && !stall && (pend_vld_reg || redir_req);
   assign apply_tgt = pend_vld_reg ? pend_tgt_reg : redir_tgt;

`ifdef PC_ALIGN_CHECK_EN
   assign misalign = apply && (apply_tgt[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= BOOT;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         BOOT:    state_next = RUN;
         RUN:     if (halt) state_next = HALT;
                  else if (misalign) state_next = FAULT;
         default: state_next = state_reg;
      endcase
   end

   always_comb begin
      valid = (state_reg == RUN);
      fault = (state_reg == FAULT);
   end

   always_comb begin
      pc_next       = pc_reg;
      pend_vld_next = 1'b0;
      pend_tgt_next = pend_tgt_reg;
      if (state_reg == RUN && !halt) begin
         if (stall) begin
            pend_vld_next = pend_vld_reg | redir_req;
            if (!pend_vld_reg && redir_req) pend_tgt_next = redir_tgt;
         end else if (apply) begin
            if (!misalign) pc_next = apply_tgt;
         end else begin
            pc_next = pc_plus4;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_reg       <= ADDR_W'(ENTRY_PC);
         pend_vld_reg <= 1'b0;
         pend_tgt_reg <= '0;
      end else begin
         pc_reg       <= pc_next;
         pend_vld_reg <= pend_vld_next;
         pend_tgt_reg <= pend_tgt_next;
      end
   end

   assign pc = pc_reg;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset/boot, branch, stall-pending, wrap, jump, halt and async reset.
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, halt = 1'b0, br_taken = 1'b0, jump = 1'b0;
   logic [15:0] br_imm = '0;
   logic [25:0] jump_idx = '0;
   logic [31:0] pc, pc_plus4;
   logic        valid, fault;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.ENTRY_PC(128), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .halt(halt), .br_taken(br_taken), .br_imm(br_imm),
      .jump(jump), .jump_idx(jump_idx), .pc(pc), .pc_plus4(pc_plus4), .valid(valid), .fault(fault)
   );

   // drive one cycle of inputs, advance one edge, then release them
   task automatic step(input logic s, input logic h, input logic b, input logic [15:0] imm,
                       input logic j, input logic [25:0] idx);
      stall = s; halt = h; br_taken = b; br_imm = imm; jump = j; jump_idx = idx;
      @(posedge clk); #1;
      stall = 0; halt = 0; br_taken = 0; br_imm = '0; jump = 0; jump_idx = '0;
      $display("step stall=%b halt=%b br=%b imm=%h jump=%b idx=%h -> pc=%h valid=%b fault=%b",
               s, h, b, imm, j, idx, pc, valid, fault);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (pc !== 32'd128) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'd128); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
      step(0, 0, 0, 16'h0, 1, 26'h40); // jump ignored in BOOT
      checks++; if (pc !== 32'd128) begin errors++; $display("FAIL boot_pc: got %h want %h", pc, 32'd128); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL boot_valid: got %b want 1", valid); end
      step(0, 0, 0, 16'h0, 0, 26'h0);
      checks++; if (pc !== 32'd132) begin errors++; $display("FAIL seq1: got %h want %h", pc, 32'd132); end
      step(0, 0, 0, 16'h0, 0, 26'h0);
      checks++; if (pc !== 32'd136) begin errors++; $display("FAIL seq2: got %h want %h", pc, 32'd136); end
   endtask

   task automatic test_branch;
      step(0, 0, 1, 16'hFFFF, 0, 26'h0); // 140 - 4
      checks++; if (pc !== 32'd136) begin errors++; $display("FAIL br_self: got %h want %h", pc, 32'd136); end
      step(0, 0, 1, 16'h0004, 0, 26'h0); // 140 + 16
      checks++; if (pc !== 32'd156) begin errors++; $display("FAIL br_fwd: got %h want %h", pc, 32'd156); end
      checks++; if (pc_plus4 !== 32'd160) begin errors++; $display("FAIL pc_plus4: got %h want %h", pc_plus4, 32'd160); end
   endtask

   task automatic test_stall;
      step(1, 0, 0, 16'h0, 0, 26'h0);
      checks++; if (pc !== 32'd156 || valid !== 1'b1) begin errors++; $display("FAIL stall_hold: got pc=%h valid=%b want 0000009c/1", pc, valid); end
      step(1, 0, 0, 16'h0, 1, 26'h40);
      checks++; if (pc !== 32'd156) begin errors++; $display("FAIL stall_jump_hold: got %h want %h", pc, 32'd156); end
      step(1, 0, 1, 16'h0010, 1, 26'h90); // second redirect while pending: ignored
      checks++; if (pc !== 32'd156) begin errors++; $display("FAIL stall_second: got %h want %h", pc, 32'd156); end
      step(0, 0, 0, 16'h0, 1, 26'h80); // pending applies, this jump dropped
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL pend_apply: got %h want %h", pc, 32'h100); end
      step(0, 0, 0, 16'h0, 0, 26'h0);
      checks++; if (pc !== 32'h104) begin errors++; $display("FAIL pend_clear: got %h want %h", pc, 32'h104); end
   endtask

   task automatic test_wrap;
      step(0, 0, 0, 16'h0, 1, 26'h0);
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL jump_zero: got %h want %h", pc, 32'h0); end
      step(0, 0, 1, 16'hFFFE, 0, 26'h0); // 4 - 8 wraps
      checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL br_wrap: got %h want %h", pc, 32'hFFFF_FFFC); end
      checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL plus4_wrap: got %h want %h", pc_plus4, 32'h0); end
      step(0, 0, 0, 16'h0, 0, 26'h0);
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL seq_wrap: got %h want %h", pc, 32'h0); end
   endtask

   task automatic test_jump;
      step(0, 0, 0, 16'h0, 1, 26'h3FF_FFFF);
      checks++; if (pc !== 32'h0FFF_FFFC) begin errors++; $display("FAIL jump_max: got %h want %h", pc, 32'h0FFF_FFFC); end
      step(0, 0, 0, 16'h0, 0, 26'h0);
      checks++; if (pc !== 32'h1000_0000) begin errors++; $display("FAIL seq_region: got %h want %h", pc, 32'h1000_0000); end
      step(0, 0, 0, 16'h0, 1, 26'h20);
      checks++; if (pc !== 32'h1000_0080) begin errors++; $display("FAIL jump_region: got %h want %h", pc, 32'h1000_0080); end
      step(0, 0, 0, 16'h0, 1, 26'h40);
      checks++; if (pc !== 32'h1000_0100) begin errors++; $display("FAIL jump_40: got %h want %h", pc, 32'h1000_0100); end
      step(0, 0, 1, 16'h0008, 1, 26'h40); // jump beats branch
      checks++; if (pc !== 32'h1000_0100) begin errors++; $display("FAIL jump_wins: got %h want %h", pc, 32'h1000_0100); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_tied: got %b want 0", fault); end
   endtask

   task automatic test_halt;
      step(1, 1, 0, 16'h0, 1, 26'h55); // halt beats stall, pending never captured
      checks++; if (valid !== 1'b0 || pc !== 32'h1000_0100) begin errors++; $display("FAIL halt_enter: got pc=%h valid=%b want 10000100/0", pc, valid); end
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, 16'h0010, 1, 26'h77);
         checks++; if (valid !== 1'b0 || pc !== 32'h1000_0100) begin errors++; $display("FAIL halt_frozen%0d: got pc=%h valid=%b want 10000100/0", i, pc, valid); end
      end
      #2 rst = 1'b1;
      #1;
      checks++; if (pc !== 32'd128 || valid !== 1'b0) begin errors++; $display("FAIL async_rst: got pc=%h valid=%b want 00000080/0", pc, valid); end
      #1 rst = 1'b0;
      step(0, 0, 0, 16'h0, 0, 26'h0);
      checks++; if (pc !== 32'd128 || valid !== 1'b1) begin errors++; $display("FAIL rst_reboot: got pc=%h valid=%b want 00000080/1", pc, valid); end
      step(0, 0, 0, 16'h0, 0, 26'h0);
      checks++; if (pc !== 32'd132) begin errors++; $display("FAIL rst_seq: got %h want %h", pc, 32'd132); end
   endtask

   initial begin
      test_reset;
      test_branch;
      test_stall;
      test_wrap;
      test_jump;
      test_halt;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
